// File: rtl/decode_stage.sv
`default_nettype none
// decode_stage: MIPS32 decode with register file, WB bypass, load-use interlock
// and a registered ID/EX output behind a valid/ready handshake.  Rev 1.0
module decode_stage #(
  parameter int DATA_W      = 32,
  parameter int REG_COUNT   = 32,
  parameter int STALL_CNT_W = 16,
  localparam int AW         = $clog2(REG_COUNT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_inst,
  input  logic [31:0]            in_pc,
  input  logic                   flush,
  input  logic                   wb_en,
  input  logic [AW-1:0]          wb_addr,
  input  logic [DATA_W-1:0]      wb_data,
  output logic                   ex_valid,
  input  logic                   ex_ready,
  output logic                   ex_reg_write,
  output logic                   ex_mem_to_reg,
  output logic                   ex_mem_write,
  output logic                   ex_branch,
  output logic                   ex_alu_src,
  output logic [3:0]             ex_alu_control,
  output logic                   ex_branch_taken,
  output logic [DATA_W-1:0]      ex_rd1,
  output logic [DATA_W-1:0]      ex_rd2,
  output logic [DATA_W-1:0]      ex_imm,
  output logic [4:0]             ex_shamt,
  output logic [AW-1:0]          ex_dest,
  output logic [31:0]            ex_pc,
  output logic                   ex_illegal,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;

  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_LUI  = 4'd9;

  logic [DATA_W-1:0] regs [REG_COUNT];

  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic [AW-1:0]     rs_a;
  logic [AW-1:0]     rt_a;
  logic [AW-1:0]     rd_a;
  logic [DATA_W-1:0] imm_se;
  logic [DATA_W-1:0] imm_lui;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic              wb_hit;

  logic              dec_reg_write;
  logic              dec_mem_to_reg;
  logic              dec_mem_write;
  logic              dec_branch;
  logic              dec_alu_src;
  logic [3:0]        dec_alu_control;
  logic [DATA_W-1:0] dec_imm;
  logic [AW-1:0]     dec_dest;
  logic              dec_illegal;
  logic              use_rs;
  logic              use_rt;

  logic              hazard;
  logic              load_en;

  assign opcode = in_inst[31:26];
  assign funct  = in_inst[5:0];
  assign rs_a   = in_inst[21 +: AW];
  assign rt_a   = in_inst[16 +: AW];
  assign rd_a   = in_inst[11 +: AW];
  assign wb_hit = wb_en && (wb_addr != '0);

  // LUI result is a 32-bit value, sign-extended from bit 31 when DATA_W > 32.
  always_comb begin
    imm_se          = {DATA_W{in_inst[15]}};
    imm_se[15:0]    = in_inst[15:0];
    imm_lui         = {DATA_W{in_inst[15]}};
    imm_lui[31:0]   = {in_inst[15:0], 16'h0000};
  end

  always_comb begin
    if (rs_a == '0)                 rd1 = '0;
    else if (wb_hit && wb_addr == rs_a) rd1 = wb_data;
    else                            rd1 = regs[rs_a];
    if (rt_a == '0)                 rd2 = '0;
    else if (wb_hit && wb_addr == rt_a) rd2 = wb_data;
    else                            rd2 = regs[rt_a];
  end

  always_comb begin
    dec_reg_write   = 1'b0;
    dec_mem_to_reg  = 1'b0;
    dec_mem_write   = 1'b0;
    dec_branch      = 1'b0;
    dec_alu_src     = 1'b0;
    dec_alu_control = ALU_AND;
    dec_imm         = imm_se;
    dec_dest        = '0;
    dec_illegal     = 1'b0;
    use_rs          = 1'b1;
    use_rt          = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        use_rt        = 1'b1;
        dec_reg_write = 1'b1;
        dec_dest      = rd_a;
        case (funct)
          FN_SLL: begin
            dec_alu_control = ALU_SLL;
            use_rs          = 1'b0;
          end
          FN_ADDU: dec_alu_control = ALU_ADD;
          FN_SUBU: dec_alu_control = ALU_SUB;
          FN_AND:  dec_alu_control = ALU_AND;
          FN_OR:   dec_alu_control = ALU_OR;
          FN_SLT:  dec_alu_control = ALU_SLT;
          default: begin
            dec_reg_write = 1'b0;
            dec_dest      = '0;
            dec_illegal   = 1'b1;
          end
        endcase
      end
      OP_ADDIU: begin
        dec_alu_control = ALU_ADD;
        dec_alu_src     = 1'b1;
        dec_reg_write   = 1'b1;
        dec_dest        = rt_a;
      end
      OP_LW: begin
        dec_alu_control = ALU_ADD;
        dec_alu_src     = 1'b1;
        dec_mem_to_reg  = 1'b1;
        dec_reg_write   = 1'b1;
        dec_dest        = rt_a;
      end
      OP_SW: begin
        dec_alu_control = ALU_ADD;
        dec_alu_src     = 1'b1;
        dec_mem_write   = 1'b1;
        use_rt          = 1'b1;
      end
      OP_BEQ: begin
        dec_alu_control = ALU_SUB;
        dec_branch      = 1'b1;
        use_rt          = 1'b1;
      end
      OP_LUI: begin
        dec_alu_control = ALU_LUI;
        dec_alu_src     = 1'b1;
        dec_reg_write   = 1'b1;
        dec_dest        = rt_a;
        dec_imm         = imm_lui;
        use_rs          = 1'b0;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  assign hazard   = ex_valid && ex_mem_to_reg && (ex_dest != '0) &&
                    ((use_rs && rs_a == ex_dest) || (use_rt && rt_a == ex_dest));
  assign load_en  = ex_ready || !ex_valid;
  assign in_ready = load_en && (flush || !hazard);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (wb_hit) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Flush and bubble only clear ex_valid; the payload fields are don't-care then.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid        <= 1'b0;
      ex_reg_write    <= 1'b0;
      ex_mem_to_reg   <= 1'b0;
      ex_mem_write    <= 1'b0;
      ex_branch       <= 1'b0;
      ex_alu_src      <= 1'b0;
      ex_alu_control  <= '0;
      ex_branch_taken <= 1'b0;
      ex_rd1          <= '0;
      ex_rd2          <= '0;
      ex_imm          <= '0;
      ex_shamt        <= '0;
      ex_dest         <= '0;
      ex_pc           <= '0;
      ex_illegal      <= 1'b0;
    end else if (load_en) begin
      if (flush) begin
        ex_valid <= 1'b0;
      end else if (in_valid && !hazard) begin
        ex_valid        <= 1'b1;
        ex_reg_write    <= dec_reg_write;
        ex_mem_to_reg   <= dec_mem_to_reg;
        ex_mem_write    <= dec_mem_write;
        ex_branch       <= dec_branch;
        ex_alu_src      <= dec_alu_src;
        ex_alu_control  <= dec_alu_control;
        ex_branch_taken <= dec_branch && (rd1 == rd2);
        ex_rd1          <= rd1;
        ex_rd2          <= rd2;
        ex_imm          <= dec_imm;
        ex_shamt        <= in_inst[10:6];
        ex_dest         <= dec_dest;
        ex_pc           <= in_pc;
        ex_illegal      <= dec_illegal;
      end else begin
        ex_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
    end else if (in_valid && hazard && !flush && !(&stall_count)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule
`default_nettype wire
